// File: rtl/aes_const.sv
// Shared AES constants and GF(2^8) helpers, also used by the MixColumns code.
package aes_const;

  localparam int Nb = 4;       // state columns
  localparam int Nk = 4;       // key length in 32-bit words (4, 6 or 8)
  localparam int Nr = Nk + 6;  // number of rounds

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_wire.sv
// Shared control types for the AES key-expansion logic.
package aes_wire;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } kexp_state_t;

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word (purely combinational).
module aes_subword (
  input  logic [7:0]  sbox [0:255],
  input  logic [31:0] w,
  output logic [31:0] sub_w
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign sub_w[8*gi +: 8] = sbox[w[8*gi +: 8]];
  end

endmodule

// File: rtl/aes_kexp_iter.sv
// Iterative AES key expansion: loads the cipher key in one cycle, then
// produces one schedule word per clock into a register file that drives KExp.
module aes_kexp_iter
  import aes_const::*;
  import aes_wire::*;
#(
  parameter  int NK = Nk,
  localparam int NR = NK + 6,
  localparam int NW = Nb * (NR + 1),
  localparam int IW = $clog2(NW)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  SBox   [0:255],
  input  logic [7:0]  Key_in [0:4*NK-1],
  input  logic        Start,
  output logic        Busy,
  output logic        Valid,
  output logic [31:0] KExp   [0:NW-1]
);

  kexp_state_t   state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [2:0]    kcnt_reg, kcnt_next;
  logic [7:0]    rcon_reg, rcon_next;
  logic          valid_reg, valid_next;
  logic          load_key, write_word;

  logic [31:0]   kexp_reg  [0:NW-1];
  logic [31:0]   kexp_next [0:NW-1];

  logic [31:0]   prev_word, back_word, rot_word, sub_in, sub_out, temp, new_word;

  // Schedule recurrence operands. Only meaningful while expanding, where
  // idx >= NK guarantees both indices stay inside the register file.
  assign prev_word = kexp_reg[idx_reg - IW'(1)];
  assign back_word = kexp_reg[idx_reg - IW'(NK)];
  assign rot_word  = {prev_word[23:0], prev_word[31:24]};
  assign sub_in    = (kcnt_reg == 3'd0) ? rot_word : prev_word;

  // One S-box bank serves both the rotated (kcnt==0) and plain (kcnt==4) cases.
  aes_subword u_subword (
    .sbox  (SBox),
    .w     (sub_in),
    .sub_w (sub_out)
  );

  // Select the transform applied to the previous word for this position.
  always_comb begin
    temp = prev_word;
    if (kcnt_reg == 3'd0) begin
      temp = sub_out ^ {rcon_reg, 24'h0};
    end else if (NK > 6 && kcnt_reg == 3'd4) begin
      temp = sub_out;
    end
  end

  assign new_word = back_word ^ temp;

  // Per-word next value: key words load on accept, later words on their index.
  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    if (gi < NK) begin : g_key
      assign kexp_next[gi] = load_key
        ? {Key_in[4*gi], Key_in[4*gi+1], Key_in[4*gi+2], Key_in[4*gi+3]}
        : kexp_reg[gi];
    end else begin : g_exp
      assign kexp_next[gi] = (write_word && idx_reg == IW'(gi)) ? new_word : kexp_reg[gi];
    end
  end

  // Next-state, counter and control decode.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    kcnt_next  = kcnt_reg;
    rcon_next  = rcon_reg;
    valid_next = valid_reg;
    load_key   = 1'b0;
    write_word = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          load_key   = 1'b1;
          idx_next   = IW'(NK);
          kcnt_next  = 3'd0;
          rcon_next  = 8'h01;
          valid_next = 1'b0;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        write_word = 1'b1;
        idx_next   = idx_reg + IW'(1);
        // kcnt tracks idx mod NK so no divider is needed.
        kcnt_next  = (kcnt_reg == 3'(NK - 1)) ? 3'd0 : kcnt_reg + 3'd1;
        if (kcnt_reg == 3'd0) begin
          rcon_next = xtime(rcon_reg);
        end
        if (idx_reg == IW'(NW - 1)) begin
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters and schedule registers; reset clears any partial schedule.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      kcnt_reg  <= 3'd0;
      rcon_reg  <= 8'h01;
      valid_reg <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        kexp_reg[i] <= 32'h0;
      end
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      kcnt_reg  <= kcnt_next;
      rcon_reg  <= rcon_next;
      valid_reg <= valid_next;
      kexp_reg  <= kexp_next;
    end
  end

  assign Busy  = (state_reg == EXPAND);
  assign Valid = valid_reg;
  assign KExp  = kexp_reg;

endmodule

// File: tb/tb_aes_kexp_iter.sv
// Scoreboard bench for aes_kexp_iter: AES-128 instance plus an Nk=8 instance.
module tb_aes_kexp_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  sbox [0:255];

  logic [7:0]  key4 [0:15];
  logic        start4, busy4, valid4;
  logic [31:0] kexp4 [0:43];

  logic [7:0]  key8 [0:31];
  logic        start8, busy8, valid8;
  logic [31:0] kexp8 [0:59];

  aes_kexp_iter #(.NK(4)) dut (
    .clk(clk), .rst(rst), .SBox(sbox), .Key_in(key4), .Start(start4),
    .Busy(busy4), .Valid(valid4), .KExp(kexp4)
  );

  aes_kexp_iter #(.NK(8)) dut8 (
    .clk(clk), .rst(rst), .SBox(sbox), .Key_in(key8), .Start(start8),
    .Busy(busy8), .Valid(valid8), .KExp(kexp8)
  );

  typedef struct packed {
    logic [7:0][5:0]  idx;
    logic [7:0][31:0] val;
    logic [3:0]       n;
    logic [7:0]       lat;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox[x] = s;
    end
  endtask

  task automatic set_key4(input logic [127:0] k);
    for (int i = 0; i < 16; i++) key4[i] = k[127-8*i -: 8];
  endtask

  task automatic set_key8(input logic [255:0] k);
    for (int i = 0; i < 32; i++) key8[i] = k[255-8*i -: 8];
  endtask

  function automatic exp_t exp_a1();
    exp_t e;
    logic [31:0] v [0:7];
    v = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605,
          32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
    e = '0;
    e.n = 4'd8;
    e.lat = 8'd40;
    for (int i = 0; i < 8; i++) begin
      e.idx[i] = 6'((i < 4) ? 4 + i : 36 + i);
      e.val[i] = v[i];
    end
    return e;
  endfunction

  function automatic exp_t exp_zero();
    exp_t e;
    logic [31:0] v [0:7];
    v = '{32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363,
          32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e};
    e = '0;
    e.n = 4'd8;
    e.lat = 8'd40;
    for (int i = 0; i < 8; i++) begin
      e.idx[i] = 6'((i < 4) ? 4 + i : 36 + i);
      e.val[i] = v[i];
    end
    return e;
  endfunction

  function automatic exp_t exp_a3();
    exp_t e;
    e = '0;
    e.n = 4'd4;
    e.lat = 8'd52;
    e.idx[0] = 6'd0;  e.val[0] = 32'h603deb10;
    e.idx[1] = 6'd7;  e.val[1] = 32'h0914dff4;
    e.idx[2] = 6'd8;  e.val[2] = 32'h9ba35411;
    e.idx[3] = 6'd59; e.val[3] = 32'h706c631e;
    return e;
  endfunction

  // Monitor for the AES-128 instance: measures latency/busy length and
  // checks the scheduled words whenever Valid rises.
  logic valid4_q = 1'b0, busy4_q = 1'b0;
  int   start_cyc4 = 0, busy_cnt4 = 0;
  always @(negedge clk) begin
    if (busy4 && !busy4_q) begin
      start_cyc4 <= cyc;
      busy_cnt4  <= 1;
    end else if (busy4) begin
      busy_cnt4 <= busy_cnt4 + 1;
    end
    if (valid4 && !valid4_q) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid4: got valid with empty queue want none");
      end else begin
        exp_t e;
        e = q4.pop_front();
        check32("latency4", 32'(cyc - start_cyc4), 32'(e.lat));
        check32("busy_cycles4", 32'(busy_cnt4), 32'(e.lat));
        for (int k = 0; k < 8; k++) begin
          if (k < int'(e.n))
            check32($sformatf("dut4_w%0d", e.idx[k]), kexp4[e.idx[k]], e.val[k]);
        end
        $display("txn dut4: schedule complete at cycle %0d, latency %0d", cyc, cyc - start_cyc4);
      end
    end
    valid4_q <= valid4;
    busy4_q  <= busy4;
  end

  // Monitor for the Nk=8 instance.
  logic valid8_q = 1'b0, busy8_q = 1'b0;
  int   start_cyc8 = 0, busy_cnt8 = 0;
  always @(negedge clk) begin
    if (busy8 && !busy8_q) begin
      start_cyc8 <= cyc;
      busy_cnt8  <= 1;
    end else if (busy8) begin
      busy_cnt8 <= busy_cnt8 + 1;
    end
    if (valid8 && !valid8_q) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid8: got valid with empty queue want none");
      end else begin
        exp_t e;
        e = q8.pop_front();
        check32("latency8", 32'(cyc - start_cyc8), 32'(e.lat));
        check32("busy_cycles8", 32'(busy_cnt8), 32'(e.lat));
        for (int k = 0; k < 8; k++) begin
          if (k < int'(e.n))
            check32($sformatf("dut8_w%0d", e.idx[k]), kexp8[e.idx[k]], e.val[k]);
        end
        $display("txn dut8: schedule complete at cycle %0d, latency %0d", cyc, cyc - start_cyc8);
      end
    end
    valid8_q <= valid8;
    busy8_q  <= busy8;
  end

  task automatic wait_valid4(input int budget);
    for (int i = 0; i < budget && !valid4; i++) @(negedge clk);
    check32("valid4_timeout", {31'h0, valid4}, 32'h1);
  endtask

  task automatic wait_valid8(input int budget);
    for (int i = 0; i < budget && !valid8; i++) @(negedge clk);
    check32("valid8_timeout", {31'h0, valid8}, 32'h1);
  endtask

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    int nz;
    rst    = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    set_key4(128'h0);
    set_key8(256'h0);
    build_sbox();
    repeat (3) @(negedge clk);

    // Reset state.
    check32("rst_valid4", {31'h0, valid4}, 32'h0);
    check32("rst_busy4", {31'h0, busy4}, 32'h0);
    check32("rst_w0", kexp4[0], 32'h0);
    check32("rst_w43", kexp4[43], 32'h0);
    check32("rst_valid8", {31'h0, valid8}, 32'h0);
    check32("rst_w59_8", kexp8[59], 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 A.1 key, single Start pulse.
    set_key4(KEY_A1);
    q4.push_back(exp_a1());
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check32("a1_busy_after_accept", {31'h0, busy4}, 32'h1);
    check32("a1_w0", kexp4[0], 32'h2b7e1516);
    wait_valid4(60);

    // Restart with the all-zero key while Valid is high.
    set_key4(128'h0);
    q4.push_back(exp_zero());
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check32("restart_valid_drop", {31'h0, valid4}, 32'h0);
    check32("restart_busy", {31'h0, busy4}, 32'h1);
    wait_valid4(60);

    // Start held through EXPAND, key changed mid-run; one restart on the Valid cycle.
    set_key4(KEY_A1);
    q4.push_back(exp_a1());
    q4.push_back(exp_zero());
    start4 = 1'b1;
    repeat (20) @(negedge clk);
    set_key4(128'h0);
    wait_valid4(60);
    @(negedge clk);
    start4 = 1'b0;
    check32("held_restart_busy", {31'h0, busy4}, 32'h1);
    check32("held_restart_valid", {31'h0, valid4}, 32'h0);
    wait_valid4(60);
    repeat (3) @(negedge clk);
    check32("held_no_second_restart", {31'h0, busy4}, 32'h0);
    check32("held_valid_sticky", {31'h0, valid4}, 32'h1);

    // Reset at cycle 20 of EXPAND aborts and clears the schedule.
    set_key4(KEY_A1);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check32("abort_valid", {31'h0, valid4}, 32'h0);
    check32("abort_busy", {31'h0, busy4}, 32'h0);
    nz = 0;
    for (int i = 0; i < 44; i++) if (kexp4[i] != 32'h0) nz++;
    check32("abort_nonzero_words", 32'(nz), 32'h0);
    q4.push_back(exp_a1());
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_valid4(60);

    // Nk=8 instance, FIPS-197 A.3 key.
    set_key8(KEY_A3);
    q8.push_back(exp_a3());
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_valid8(80);

    repeat (2) @(negedge clk);
    check32("q4_drained", 32'(q4.size()), 32'h0);
    check32("q8_drained", 32'(q8.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
